// File: rtl/logo_motion_scheduler.sv
// logo_motion_scheduler
// Per-frame motion controller for the bouncing-logo sprite. On each accepted
// frame_start the inputs are snapshotted, X and Y are computed into shadow
// registers over two cycles, and everything is committed together in a single
// cycle so the pixel path only ever sees frame-stable position and colour.
// Build option: define CORNER_HIT_EN to add the corner_hit output. A corner
// hit (both axes bouncing in the same frame) then advances the colour by 4.
module logo_motion_scheduler #(
    parameter int LOGO_SIZE      = 128,
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int IDLE_FRAMES    = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pause,
    input  logic [1:0] speed,
    input  logic       pad_up,
    input  logic       pad_down,
    input  logic       pad_left,
    input  logic       pad_right,
    input  logic       pad_start,
    output logic [9:0] logo_left,
    output logic [8:0] logo_top,
    output logic [2:0] color_index,
    output logic       manual_mode,
    output logic       bounce,
    output logic       update_done
`ifdef CORNER_HIT_EN
    ,
    output logic       corner_hit
`endif
);

    localparam logic [10:0] X_MAX = 11'(DISPLAY_WIDTH - LOGO_SIZE);
    localparam logic [10:0] Y_MAX = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
    localparam int          CNT_W = $clog2(IDLE_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC_X = 2'd1,
        ST_CALC_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // One axis step. Returns {new_pos[9:0], new_dir, bounced}.
    // inc is the pad that moves the axis towards lim, dec the one towards 0;
    // dec wins the direction override when both are held in auto mode.
    function automatic logic [11:0] axis_next(
        input logic [10:0] pos,
        input logic        dir,
        input logic [10:0] step,
        input logic [10:0] lim,
        input logic        man,
        input logic        inc,
        input logic        dec
    );
        logic signed [10:0] p;
        logic signed [10:0] s;
        logic signed [10:0] m;
        logic signed [10:0] n;
        logic               d;
        logic               b;
        p = signed'(pos);
        s = signed'(step);
        m = signed'(lim);
        d = dir;
        b = 1'b0;
        if (man) begin
            if (inc && !dec) begin
                n = p + s;
            end else if (dec && !inc) begin
                n = p - s;
            end else begin
                n = p;
            end
            if (n > m) begin
                n = m;
            end else if (n < 11'sd0) begin
                n = 11'sd0;
            end else begin
                b = 1'b0;
            end
        end else begin
            if (dec) begin
                d = 1'b0;
            end else if (inc) begin
                d = 1'b1;
            end else begin
                d = dir;
            end
            if (d) begin
                n = p + s;
            end else begin
                n = p - s;
            end
            if (d && (n >= m)) begin
                n = m;
                d = 1'b0;
                b = 1'b1;
            end else if (!d && (n <= 11'sd0)) begin
                n = 11'sd0;
                d = 1'b1;
                b = 1'b1;
            end else begin
                b = 1'b0;
            end
        end
        return {n[9:0], d, b};
    endfunction

    state_t           state_r;
    state_t           state_next;

    logic             snap_pause_r;
    logic [1:0]       snap_speed_r;
    logic             snap_up_r;
    logic             snap_down_r;
    logic             snap_left_r;
    logic             snap_right_r;
    logic             snap_start_r;
    logic             start_prev_r;

    logic             dir_x_r;
    logic             dir_y_r;
    logic [9:0]       x_sh_r;
    logic [8:0]       y_sh_r;
    logic             dir_x_sh_r;
    logic             dir_y_sh_r;
    logic             bx_r;
    logic             by_r;
    logic [CNT_W-1:0] idle_cnt_r;

    logic [10:0]      step_s;
    logic [11:0]      x_res_s;
    logic [11:0]      y_res_s;
    logic [8:0]       y_top_s;
    logic             any_pad_s;

    assign step_s    = {9'd0, snap_speed_r} + 11'd1;
    assign any_pad_s = snap_up_r | snap_down_r | snap_left_r | snap_right_r;

    // Candidate next position/direction for each axis from the snapshot
    always_comb begin
        x_res_s = axis_next({1'b0, logo_left}, dir_x_r, step_s, X_MAX,
                            manual_mode, snap_right_r, snap_left_r);
        y_res_s = axis_next({2'b00, logo_top}, dir_y_r, step_s, Y_MAX,
                            manual_mode, snap_down_r, snap_up_r);
        y_top_s = 9'(y_res_s[11:2]);
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Sequencer next state: frame_start is only honoured while idle
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_CALC_X;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC_X: state_next = ST_CALC_Y;
            ST_CALC_Y: state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Snapshot inputs, build shadow results, then commit them in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_pause_r <= 1'b0;
            snap_speed_r <= 2'd0;
            snap_up_r    <= 1'b0;
            snap_down_r  <= 1'b0;
            snap_left_r  <= 1'b0;
            snap_right_r <= 1'b0;
            snap_start_r <= 1'b0;
            start_prev_r <= 1'b0;
            dir_x_r      <= 1'b1;
            dir_y_r      <= 1'b0;
            x_sh_r       <= 10'd0;
            y_sh_r       <= 9'd0;
            dir_x_sh_r   <= 1'b0;
            dir_y_sh_r   <= 1'b0;
            bx_r         <= 1'b0;
            by_r         <= 1'b0;
            idle_cnt_r   <= {CNT_W{1'b0}};
            logo_left    <= 10'd200;
            logo_top     <= 9'd200;
            color_index  <= 3'd0;
            manual_mode  <= 1'b0;
            bounce       <= 1'b0;
            update_done  <= 1'b0;
`ifdef CORNER_HIT_EN
            corner_hit   <= 1'b0;
`endif
        end else begin
            bounce      <= 1'b0;
            update_done <= 1'b0;
`ifdef CORNER_HIT_EN
            corner_hit  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        snap_pause_r <= pause;
                        snap_speed_r <= speed;
                        snap_up_r    <= pad_up;
                        snap_down_r  <= pad_down;
                        snap_left_r  <= pad_left;
                        snap_right_r <= pad_right;
                        snap_start_r <= pad_start;
                    end
                end
                ST_CALC_X: begin
                    if (snap_pause_r) begin
                        x_sh_r     <= logo_left;
                        dir_x_sh_r <= dir_x_r;
                        bx_r       <= 1'b0;
                    end else begin
                        x_sh_r     <= x_res_s[11:2];
                        dir_x_sh_r <= x_res_s[1];
                        bx_r       <= x_res_s[0];
                    end
                end
                ST_CALC_Y: begin
                    if (snap_pause_r) begin
                        y_sh_r     <= logo_top;
                        dir_y_sh_r <= dir_y_r;
                        by_r       <= 1'b0;
                    end else begin
                        y_sh_r     <= y_top_s;
                        dir_y_sh_r <= y_res_s[1];
                        by_r       <= y_res_s[0];
                    end
                end
                ST_COMMIT: begin
                    logo_left   <= x_sh_r;
                    logo_top    <= y_sh_r;
                    dir_x_r     <= dir_x_sh_r;
                    dir_y_r     <= dir_y_sh_r;
                    bounce      <= bx_r | by_r;
                    update_done <= 1'b1;
`ifdef CORNER_HIT_EN
                    corner_hit  <= bx_r & by_r;
                    if (bx_r && by_r) begin
                        color_index <= color_index + 3'd4;
                    end else if (bx_r || by_r) begin
                        color_index <= color_index + 3'd1;
                    end
`else
                    if (bx_r || by_r) begin
                        color_index <= color_index + 3'd1;
                    end
`endif
                    // A start edge toggles the mode and overrides the timeout.
                    start_prev_r <= snap_start_r;
                    if (snap_start_r && !start_prev_r) begin
                        manual_mode <= ~manual_mode;
                        idle_cnt_r  <= {CNT_W{1'b0}};
                    end else if (manual_mode && !snap_pause_r) begin
                        if (any_pad_s) begin
                            idle_cnt_r <= {CNT_W{1'b0}};
                        end else if (idle_cnt_r == CNT_W'(IDLE_FRAMES - 1)) begin
                            manual_mode <= 1'b0;
                            idle_cnt_r  <= {CNT_W{1'b0}};
                        end else begin
                            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    bounce <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logo_motion_scheduler.sv
// Scoreboard bench for logo_motion_scheduler. A per-frame reference model
// pushes the expected committed state when frame_start is driven; the entry
// is popped and compared when update_done is observed.
module tb_logo_motion_scheduler;

    localparam int XMAX = 512;
    localparam int YMAX = 352;
    localparam int IDLE = 4;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       pause;
    logic [1:0] speed;
    logic       pad_up;
    logic       pad_down;
    logic       pad_left;
    logic       pad_right;
    logic       pad_start;
    logic [9:0] logo_left;
    logic [8:0] logo_top;
    logic [2:0] color_index;
    logic       manual_mode;
    logic       bounce;
    logic       update_done;
`ifdef CORNER_HIT_EN
    logic       corner_hit;
`endif

    logo_motion_scheduler #(.IDLE_FRAMES(IDLE)) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .pause(pause),
        .speed(speed),
        .pad_up(pad_up),
        .pad_down(pad_down),
        .pad_left(pad_left),
        .pad_right(pad_right),
        .pad_start(pad_start),
        .logo_left(logo_left),
        .logo_top(logo_top),
        .color_index(color_index),
        .manual_mode(manual_mode),
        .bounce(bounce),
        .update_done(update_done)
`ifdef CORNER_HIT_EN
        ,
        .corner_hit(corner_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int col;
        int man;
        int bnc;
        int crn;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    int m_x, m_y, m_dx, m_dy, m_col, m_man, m_cnt, m_sp;

    task automatic check_value(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 200; m_y = 200; m_dx = 1; m_dy = 0;
        m_col = 0; m_man = 0; m_cnt = 0; m_sp = 0;
    endtask

    task automatic model_frame(input int spd, input bit pse, input bit st,
                               input bit up, input bit dn, input bit lf, input bit rt);
        int   step;
        bit   bx;
        bit   by;
        exp_t e;
        step = spd + 1;
        bx = 1'b0;
        by = 1'b0;
        if (!pse) begin
            if (m_man != 0) begin
                if (rt && !lf) m_x = (m_x + step > XMAX) ? XMAX : m_x + step;
                else if (lf && !rt) m_x = (m_x - step < 0) ? 0 : m_x - step;
                if (dn && !up) m_y = (m_y + step > YMAX) ? YMAX : m_y + step;
                else if (up && !dn) m_y = (m_y - step < 0) ? 0 : m_y - step;
            end else begin
                if (lf) m_dx = 0; else if (rt) m_dx = 1;
                if (up) m_dy = 0; else if (dn) m_dy = 1;
                if (m_dx == 1) begin
                    m_x = m_x + step;
                    if (m_x >= XMAX) begin m_x = XMAX; m_dx = 0; bx = 1'b1; end
                end else begin
                    m_x = m_x - step;
                    if (m_x <= 0) begin m_x = 0; m_dx = 1; bx = 1'b1; end
                end
                if (m_dy == 1) begin
                    m_y = m_y + step;
                    if (m_y >= YMAX) begin m_y = YMAX; m_dy = 0; by = 1'b1; end
                end else begin
                    m_y = m_y - step;
                    if (m_y <= 0) begin m_y = 0; m_dy = 1; by = 1'b1; end
                end
`ifdef CORNER_HIT_EN
                if (bx && by) m_col = (m_col + 4) % 8;
                else if (bx || by) m_col = (m_col + 1) % 8;
`else
                if (bx || by) m_col = (m_col + 1) % 8;
`endif
            end
        end
        if (st && m_sp == 0) begin
            m_man = 1 - m_man;
            m_cnt = 0;
        end else if (m_man != 0 && !pse) begin
            if (up || dn || lf || rt) m_cnt = 0;
            else if (m_cnt + 1 == IDLE) begin m_man = 0; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end
        m_sp = st ? 1 : 0;
        e.x = m_x; e.y = m_y; e.col = m_col; e.man = m_man;
        e.bnc = (bx || by) ? 1 : 0;
        e.crn = (bx && by) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_left"}, logo_left, 200);
        check_value({tag, "_top"}, logo_top, 200);
        check_value({tag, "_color"}, color_index, 0);
        check_value({tag, "_manual"}, manual_mode, 0);
        check_value({tag, "_bounce"}, bounce, 0);
        check_value({tag, "_done"}, update_done, 0);
    endtask

    // Drive one frame; hold2 keeps frame_start high into CALC_X.
    task automatic do_frame(input logic [1:0] spd, input bit pse, input bit st,
                            input bit up, input bit dn, input bit lf, input bit rt,
                            input bit hold2);
        int   first;
        int   pulses;
        exp_t e;
        @(negedge clk);
        speed = spd; pause = pse; pad_start = st;
        pad_up = up; pad_down = dn; pad_left = lf; pad_right = rt;
        frame_start = 1'b1;
        model_frame(int'(spd), pse, st, up, dn, lf, rt);
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!hold2) frame_start = 1'b0;
                // inputs after the snapshot edge must not matter
                {pad_start, pad_up, pad_down, pad_left, pad_right} = 5'($urandom);
                pause = 1'($urandom);
                speed = 2'($urandom);
            end
            if (i == 2) frame_start = 1'b0;
            if (update_done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    check_value("sb_level", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_value("left", logo_left, e.x);
                        check_value("top", logo_top, e.y);
                        check_value("color", color_index, e.col);
                        check_value("manual", manual_mode, e.man);
                        check_value("bounce", bounce, e.bnc);
`ifdef CORNER_HIT_EN
                        check_value("corner_hit", corner_hit, e.crn);
`endif
                    end
                end
            end
        end
        check_value("latency", first, 4);
        check_value("done_pulses", pulses, 1);
        if (first == 0 && sb.size() > 0) e = sb.pop_front();
    endtask

    initial begin : main
        int cnt;
        bit st, up, dn, lf, rt, pse;
        reset = 1'b1; frame_start = 1'b0; pause = 1'b0; speed = 2'd0;
        pad_up = 1'b0; pad_down = 1'b0; pad_left = 1'b0; pad_right = 1'b0; pad_start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        model_reset();

        // first frame, slowest speed: 201/199
        do_frame(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // auto run: top bounce then right-edge bounce at exactly 512
        repeat (80) do_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // enter manual, drive into the bottom-right clamp and stay there
        do_frame(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (60) do_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // back off to 510/350, then return to auto
        do_frame(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_frame(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // both axes forced positive: simultaneous bounce at 512/352
        do_frame(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // pause frames and a frame_start held into CALC_X
        repeat (2) do_frame(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // manual mode: opposing pads, idle counter restart, timeout
        do_frame(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) do_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) do_frame(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // random mix, start level sometimes held across frames
        for (int k = 0; k < 60; k++) begin
            st  = ($urandom_range(0, 5) == 0);
            up  = 1'($urandom); dn = 1'($urandom);
            lf  = 1'($urandom); rt = 1'($urandom);
            pse = ($urandom_range(0, 5) == 0);
            if (pse) begin st = 1'b0; up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0; end
            do_frame(2'($urandom), pse, st, up, dn, lf, rt, 1'b0);
        end

        // reset in the middle of a frame: no commit afterwards
        @(negedge clk);
        speed = 2'd3; pause = 1'b0; pad_start = 1'b0;
        pad_up = 1'b0; pad_down = 1'b0; pad_left = 1'b0; pad_right = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (update_done === 1'b1) cnt++;
        end
        check_value("midrst_no_done", cnt, 0);
        do_frame(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/logo_motion_scheduler.md
Name: logo_motion_scheduler

Overview:
- Per-frame motion controller for the bouncing-logo sprite datapath.
- Once per frame it computes the next logo position in a short multi-cycle sequence, and outputs bounce/colour events.
- It also handles the switch between auto-bounce and gamepad manual mode, including an idle timeout back to auto.
- Sits between the VGA sync generator / gamepad receiver and the pixel/colour path. The pixel path sees only committed, frame-stable position and colour registers.

Parameters:
- LOGO_SIZE, 128, logo edge length in pixels.
- DISPLAY_WIDTH, 640, visible width; X_MAX = DISPLAY_WIDTH-LOGO_SIZE (512).
- DISPLAY_HEIGHT, 480, visible height; Y_MAX = DISPLAY_HEIGHT-LOGO_SIZE (352).
- IDLE_FRAMES, 600, manual-mode frames with no d-pad input before reverting to auto.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle strobe at pix_x==0 && pix_y==0
- pause  in  1  freeze motion (position and direction held)
- speed  in  2  step per frame = speed+1 pixels (1..4)
- pad_up, pad_down, pad_left, pad_right, pad_start  in  1 each  gamepad levels
- logo_left  out  10  committed X position
- logo_top  out  9  committed Y position
- color_index  out  3  palette index
- manual_mode  out  1  1 = gamepad-driven
- bounce  out  1  one-cycle pulse on commit if any axis bounced
- update_done  out  1  one-cycle pulse on commit

Behaviour:
- Reset values (async on reset=1):
  - logo_left=200, logo_top=200, dir_x=1 (right), dir_y=0 (up).
  - color_index=0, manual_mode=0, bounce=0, update_done=0.
  - FSM=IDLE, idle counter=0, start_prev=0.
- FSM sequence: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE.
- Leaving IDLE: only when frame_start=1, sampled in IDLE. At that edge all pad_* inputs, pause and speed are snapshotted.
- frame_start while not in IDLE: ignored.
- Latency: outputs update at the 3rd edge after the frame_start edge. update_done is high for exactly that cycle.
- Output stability: logo_left, logo_top, color_index and manual_mode change only on the COMMIT edge. Shadow registers hold intermediate results.
- Arithmetic: 11-bit signed intermediate. Results are clamped to [0,X_MAX] / [0,Y_MAX]; wrap-around is never permitted.
- Auto mode, CALC_X:
  - Direction override first: left -> dir_x=0, else right -> dir_x=1.
  - Then new = left ± step.
  - If moving right and new >= X_MAX: new=X_MAX, dir_x=0, bounce_x=1.
  - If moving left and new <= 0: new=0, dir_x=1, bounce_x=1.
- Auto mode, CALC_Y: same rules with up/down, Y_MAX and dir_y.
- Auto mode, COMMIT: if bounce_x|bounce_y, color_index += 1 (wraps 7->0). A simultaneous two-axis bounce adds only 1. bounce pulses.
- Manual mode, CALC_X/CALC_Y:
  - Each pressed d-pad direction moves by step, clamped to range.
  - Opposite directions pressed together: no movement on that axis.
  - No direction changes, no bounce, colour unchanged.
- pause=1 snapshot: positions, directions and colour unchanged. update_done still pulses; idle counter not advanced.
- Mode toggle: snapshot pad_start=1 with start_prev=0 toggles manual_mode at COMMIT. start_prev updates every frame.
- Idle timeout (manual mode):
  - Counter resets on any d-pad snapshot high, or on entering manual.
  - Otherwise it increments per frame.
  - On reaching IDLE_FRAMES: manual_mode <= 0 and counter cleared.
  - A start edge in the same frame takes priority (toggle only).
- Reset asserted mid-sequence: immediate return to reset values. No partial commit.

Optional Feature:
- Macro: CORNER_HIT_EN.
- Defined:
  - Adds output corner_hit (1 bit), a one-cycle pulse at COMMIT when bounce_x and bounce_y occur in the same frame.
  - On a corner hit, color_index += 4 instead of +1.
- Undefined:
  - No corner_hit port; any bounce adds 1.

Test Plan:
- Reset, then 1 frame_start with speed=0 and no pads -> after 3 edges left=201, top=199, update_done 1 cycle, color 0.
- Force left=510, dir_x=1, speed=3 -> left=512, dir_x=0, bounce=1, color=1. Next frame -> left=508.
- Left=510, top=350, both dirs positive, speed=3 -> left=512, top=352, color +1 (+4 and corner_hit=1 with CORNER_HIT_EN).
- pad_start pulse -> manual_mode=1. right held at left=511, speed=3 -> 512 then stays 512. IDLE_FRAMES=4 with no pads -> manual_mode=0 after 4th frame.
- frame_start reasserted during CALC_X -> ignored, exactly one update_done. pause=1 -> position unchanged, update_done still pulses.
- reset pulsed during CALC_Y -> outputs return to 200/200/0, no update_done.
